// File: rtl/step_tracker.sv
// step_tracker: receive-side step counter, per-window rate meter and
// activity classifier (idle/walk/jog/run) with hysteresis.
// Optional macro STEP_TRACKER_SYNC_EN: when defined, pulse_in goes through a
// 2-flop synchronizer before edge detection (adds 2 cycles of step latency).
//
// Output handshake: rate_valid is a one-cycle strobe with no ready/backpressure;
// rate holds its value until the next strobe, so a consumer may capture it on
// the strobe cycle or any later cycle before the next window closes.
module step_tracker #(
  parameter int WIN_CYCLES = 100_000_000,
  parameter int JOG_MIN    = 48,
  parameter int RUN_MIN    = 96,
  parameter int HOLD       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_in,
  input  logic       clear,
  output logic [15:0] step_count,
  output logic [7:0]  rate,
  output logic        rate_valid,
  output logic [1:0]  activity
);

  localparam int CW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WALK = 2'b01,
    JOG  = 2'b10,
    RUN  = 2'b11
  } act_e;

  logic          pulse_s;
  logic          step;
  logic          win_close;
  logic [9:0]    win_sum;
  logic [7:0]    rate_sat;

  logic          prev_q,       prev_d;
  logic [15:0]   step_count_q, step_count_d;
  logic [CW-1:0] win_cnt_q,    win_cnt_d;
  logic [8:0]    win_steps_q,  win_steps_d;
  logic [7:0]    rate_q,       rate_d;
  logic          rate_valid_q, rate_valid_d;

  act_e          state_q;
  act_e          pend_q;
  act_e          cand;
  logic [HW-1:0] hcnt_q;
  logic [HW-1:0] hcnt_inc;

`ifdef STEP_TRACKER_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for an asynchronous step source.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
    end
  end

  assign pulse_s = sync2_q;
`else
  assign pulse_s = pulse_in;
`endif

  assign step      = pulse_s & ~prev_q;
  assign win_close = (win_cnt_q == WIN_LAST);
  assign win_sum   = {1'b0, win_steps_q} + {9'd0, step};
  assign rate_sat  = (win_sum > 10'd255) ? 8'hFF : win_sum[7:0];

  // Next-state for edge detect, step counter, window counter and rate.
  always_comb begin
    prev_d       = pulse_s;
    step_count_d = step_count_q;
    win_steps_d  = win_steps_q;
    win_cnt_d    = win_cnt_q + CW'(1);
    rate_d       = rate_q;
    rate_valid_d = 1'b0;

    if (step && (step_count_q != 16'hFFFF)) begin
      step_count_d = step_count_q + 16'd1;
    end

    if (win_close) begin
      // A step on the closing cycle belongs to the window being closed.
      rate_d       = rate_sat;
      rate_valid_d = 1'b1;
      win_steps_d  = 9'd0;
      win_cnt_d    = '0;
    end else if (step && (win_steps_q != 9'h1FF)) begin
      win_steps_d = win_steps_q + 9'd1;
    end

    // Clear discards the partial window and drops a coincident step.
    if (clear) begin
      step_count_d = 16'd0;
      win_steps_d  = 9'd0;
      win_cnt_d    = '0;
      rate_d       = 8'd0;
      rate_valid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= 1'b0;
      step_count_q <= 16'd0;
      win_cnt_q    <= '0;
      win_steps_q  <= 9'd0;
      rate_q       <= 8'd0;
      rate_valid_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      step_count_q <= step_count_d;
      win_cnt_q    <= win_cnt_d;
      win_steps_q  <= win_steps_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
    end
  end

  // Candidate class from the registered window rate.
  always_comb begin
    cand = IDLE;
    if (rate_q == 8'd0) begin
      cand = IDLE;
    end else if (int'(rate_q) < JOG_MIN) begin
      cand = WALK;
    end else if (int'(rate_q) < RUN_MIN) begin
      cand = JOG;
    end else begin
      cand = RUN;
    end
  end

  assign hcnt_inc = hcnt_q + HW'(1);

  // Classifier FSM: a new class must repeat HOLD windows before it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= IDLE;
      hcnt_q  <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else if (rate_valid_q) begin
      if (cand == state_q) begin
        hcnt_q <= '0;
      end else if (cand == pend_q) begin
        if (int'(hcnt_inc) >= HOLD) begin
          state_q <= cand;
          hcnt_q  <= '0;
        end else begin
          hcnt_q <= hcnt_inc;
        end
      end else begin
        pend_q <= cand;
        if (HOLD <= 1) begin
          state_q <= cand;
          hcnt_q  <= '0;
        end else begin
          hcnt_q <= HW'(1);
        end
      end
    end
  end

  assign step_count = step_count_q;
  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign activity   = state_q;

endmodule
